// File: rtl/swc_rtu_rsp_queue.sv
// Per-port RTU response FIFO; FWFT registered head: 1-cycle push-to-valid latency, no bubble on back-to-back acks.
// rtu_ready_o is registered; offers while not ready are lost and flagged on overflow_o. Option: SWC_RTU_RSP_ZERO_MASK_DROP_EN.
module swc_rtu_rsp_queue #(
  parameter int g_num_ports  = 11,
  parameter int g_prio_width = 3,
  parameter int g_depth      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         rtu_valid_i,
  output logic                         rtu_ready_o,
  input  logic [g_num_ports-1:0]       rtu_dst_port_mask_i,
  input  logic                         rtu_drop_i,
  input  logic [g_prio_width-1:0]      rtu_prio_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ack_i,
  output logic [g_num_ports-1:0]       rsp_dst_port_mask_o,
  output logic                         rsp_drop_o,
  output logic [g_prio_width-1:0]      rsp_prio_o,
  output logic [$clog2(g_depth):0]     level_o,
  output logic                         overflow_o
);

  localparam int c_aw = $clog2(g_depth);

  typedef struct packed {
    logic [g_num_ports-1:0]  mask;
    logic                    drop;
    logic [g_prio_width-1:0] prio;
  } entry_t;

  entry_t        r_mem [g_depth];
  entry_t        r_head;
  entry_t        w_wr_entry;
  logic [c_aw:0] r_wr_ptr;
  logic [c_aw:0] r_rd_ptr;
  logic [c_aw:0] w_wr_ptr_nxt;
  logic [c_aw:0] w_rd_ptr_nxt;
  logic [c_aw:0] w_level;
  logic          r_ready;
  logic          r_valid;
  logic          r_overflow;
  logic          w_push;
  logic          w_pop;
  logic          w_load;
  logic          w_full_nxt;

  assign w_push = rtu_valid_i & r_ready;
  assign w_pop  = rsp_ack_i & r_valid;

  assign w_wr_ptr_nxt = r_wr_ptr + {{c_aw{1'b0}}, w_push};
  assign w_rd_ptr_nxt = r_rd_ptr + {{c_aw{1'b0}}, w_pop};
  assign w_level      = r_wr_ptr - r_rd_ptr;

  assign w_full_nxt = (w_wr_ptr_nxt[c_aw-1:0] == w_rd_ptr_nxt[c_aw-1:0]) &&
                      (w_wr_ptr_nxt[c_aw] != w_rd_ptr_nxt[c_aw]);

  // Head reloads from the entry behind it on pop, or fills an empty head slot.
  assign w_load = r_valid ? (w_pop && (w_level >= (c_aw+1)'(2)))
                          : (w_level != '0);

  always_comb begin
    w_wr_entry.mask = rtu_dst_port_mask_i;
    w_wr_entry.drop = rtu_drop_i;
    w_wr_entry.prio = rtu_prio_i;
`ifdef SWC_RTU_RSP_ZERO_MASK_DROP_EN
    if (rtu_dst_port_mask_i == '0) begin
      w_wr_entry.drop = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_head     <= '0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_ready    <= ~w_full_nxt;
      r_overflow <= rtu_valid_i & ~r_ready;
      r_valid    <= w_load | (r_valid & ~w_pop);
      if (w_load) begin
        r_head <= r_mem[w_rd_ptr_nxt[c_aw-1:0]];
      end
    end
  end

  assign rtu_ready_o         = r_ready;
  assign rsp_valid_o         = r_valid;
  assign rsp_dst_port_mask_o = r_head.mask;
  assign rsp_drop_o          = r_head.drop;
  assign rsp_prio_o          = r_head.prio;
  assign level_o             = w_level;
  assign overflow_o          = r_overflow;

endmodule

// File: tb/tb_swc_rtu_rsp_queue.sv
// Directed bench for swc_rtu_rsp_queue with an in-order scoreboard of accepted responses.
module tb_swc_rtu_rsp_queue;

  localparam int NP = 11;
  localparam int PW = 3;
  localparam int DW = NP + 1 + PW;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          rtu_valid_i;
  logic          rtu_ready_o;
  logic [NP-1:0] rtu_dst_port_mask_i;
  logic          rtu_drop_i;
  logic [PW-1:0] rtu_prio_i;
  logic          rsp_valid_o;
  logic          rsp_ack_i;
  logic [NP-1:0] rsp_dst_port_mask_o;
  logic          rsp_drop_o;
  logic [PW-1:0] rsp_prio_o;
  logic [2:0]    level_o;
  logic          overflow_o;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] sb[$];

  swc_rtu_rsp_queue #(.g_num_ports(NP), .g_prio_width(PW), .g_depth(4)) dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .rtu_valid_i         (rtu_valid_i),
    .rtu_ready_o         (rtu_ready_o),
    .rtu_dst_port_mask_i (rtu_dst_port_mask_i),
    .rtu_drop_i          (rtu_drop_i),
    .rtu_prio_i          (rtu_prio_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_ack_i           (rsp_ack_i),
    .rsp_dst_port_mask_o (rsp_dst_port_mask_o),
    .rsp_drop_o          (rsp_drop_o),
    .rsp_prio_o          (rsp_prio_o),
    .level_o             (level_o),
    .overflow_o          (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [NP-1:0] m, input logic d, input logic [PW-1:0] p);
    logic dd;
    dd = d;
`ifdef SWC_RTU_RSP_ZERO_MASK_DROP_EN
    if (m == '0) dd = 1'b1;
`endif
    return {m, dd, p};
  endfunction

  function automatic logic [31:0] head();
    return 32'({rsp_dst_port_mask_o, rsp_drop_o, rsp_prio_o});
  endfunction

  // Called at a negedge; drives one clock cycle and returns at the next negedge.
  task automatic cycle(input logic v, input logic [NP-1:0] m, input logic d,
                       input logic [PW-1:0] p, input logic a);
    logic acc;
    logic pop;
    rtu_valid_i         = v;
    rtu_dst_port_mask_i = m;
    rtu_drop_i          = d;
    rtu_prio_i          = p;
    rsp_ack_i           = a;
    #1;
    acc = v & rtu_ready_o;
    pop = a & rsp_valid_o;
    if (pop) begin
      if (sb.size() > 0) chk("pop_data", head(), 32'(sb.pop_front()));
      else               chk("pop_unexpected", 32'(rsp_valid_o), 32'd0);
    end
    if (acc) sb.push_back(model(m, d, p));
    @(posedge clk_i);
    @(negedge clk_i);
    rtu_valid_i = 1'b0;
    rsp_ack_i   = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst_n_i = 1'b0;
    rtu_valid_i = 1'b0; rtu_dst_port_mask_i = '0; rtu_drop_i = 1'b0; rtu_prio_i = '0; rsp_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", 32'(rtu_ready_o), 32'd0);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_ovf",   32'(overflow_o), 32'd0);
    chk("rst_data",  head(), 32'd0);
    rst_n_i = 1'b1;
    #1 chk("rel_ready_pre", 32'(rtu_ready_o), 32'd0);
    @(negedge clk_i);
    chk("rel_ready", 32'(rtu_ready_o), 32'd1);

    // single entry
    cycle(1'b1, 11'h005, 1'b0, 3'd5, 1'b0);
    chk("single_lat_valid", 32'(rsp_valid_o), 32'd0);
    chk("single_lvl1", 32'(level_o), 32'd1);
    idle();
    chk("single_valid", 32'(rsp_valid_o), 32'd1);
    chk("single_data", head(), 32'(model(11'h005, 1'b0, 3'd5)));
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    chk("single_valid_low", 32'(rsp_valid_o), 32'd0);
    chk("single_lvl0", 32'(level_o), 32'd0);

    // fill to depth, then overflow
    for (int i = 0; i < 4; i++) cycle(1'b1, 11'(11'h100 + i), i[0], 3'(i), 1'b0);
    chk("full_ready", 32'(rtu_ready_o), 32'd0);
    chk("full_level", 32'(level_o), 32'd4);
    cycle(1'b1, 11'h7ff, 1'b1, 3'd7, 1'b0);
    chk("ovf_pulse", 32'(overflow_o), 32'd1);
    chk("ovf_level", 32'(level_o), 32'd4);
    idle();
    chk("ovf_clear", 32'(overflow_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_vld", 32'(rsp_valid_o), 32'd1);
      chk("drain_prio", 32'(rsp_prio_o), 32'(i));
      cycle(1'b0, '0, 1'b0, '0, 1'b1);
    end
    chk("drain_empty_vld", 32'(rsp_valid_o), 32'd0);
    chk("drain_empty_lvl", 32'(level_o), 32'd0);
    chk("drain_ready", 32'(rtu_ready_o), 32'd1);

    // concurrent push/pop at level 2
    cycle(1'b1, 11'h011, 1'b0, 3'd1, 1'b0);
    cycle(1'b1, 11'h022, 1'b1, 3'd2, 1'b0);
    idle();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 11'($urandom_range(1, 2047)), 1'($urandom_range(0, 1)), 3'(i), 1'b1);
      chk("conc_level", 32'(level_o), 32'd2);
      chk("conc_valid", 32'(rsp_valid_o), 32'd1);
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1);
    chk("conc_drained", 32'(level_o), 32'd0);

    // ack while empty
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, '0, 1'b1);
      chk("ack_empty_lvl", 32'(level_o), 32'd0);
      chk("ack_empty_vld", 32'(rsp_valid_o), 32'd0);
    end

    // reset mid-operation with level 3
    for (int i = 0; i < 3; i++) cycle(1'b1, 11'(11'h040 << i), 1'b0, 3'(i + 4), 1'b0);
    idle();
    chk("pre_rst_level", 32'(level_o), 32'd3);
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("mid_rst_level", 32'(level_o), 32'd0);
    chk("mid_rst_ready", 32'(rtu_ready_o), 32'd0);
    chk("mid_rst_data",  head(), 32'd0);
    sb.delete();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1 chk("mid_rel_ready_pre", 32'(rtu_ready_o), 32'd0);
    @(negedge clk_i);
    chk("mid_rel_ready", 32'(rtu_ready_o), 32'd1);
    chk("mid_rel_level", 32'(level_o), 32'd0);

    // zero-mask entry
    cycle(1'b1, 11'h000, 1'b0, 3'd2, 1'b0);
    idle();
    chk("zmask_valid", 32'(rsp_valid_o), 32'd1);
`ifdef SWC_RTU_RSP_ZERO_MASK_DROP_EN
    chk("zmask_drop", 32'(rsp_drop_o), 32'd1);
`else
    chk("zmask_drop", 32'(rsp_drop_o), 32'd0);
`endif
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    chk("zmask_done", 32'(level_o), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swc_rtu_rsp_queue.md
# swc_rtu_rsp_queue

Per-port elastic buffer between the RTU and the switch core's RTU response input. Accepts routing decisions (destination port mask, drop flag, priority) from the RTU at any rate and presents them to the core one at a time through the valid/ack handshake the core uses on `rtu_rsp_valid_i` / `rtu_rsp_ack_o`. One instance per switch port, so RTU lookup latency is decoupled from the core's input block.

## Interface
- `g_num_ports`, 11: width of the destination port mask.
- `g_prio_width`, 3: priority field width.
- `g_depth`, 4: queue depth in entries; power of two, 2..16.

- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `rtu_valid_i`  in  1  RTU presents a response this cycle.
- `rtu_ready_o`  out  1  queue accepts a response this cycle.
- `rtu_dst_port_mask_i`  in  g_num_ports  destination mask from RTU.
- `rtu_drop_i`  in  1  drop decision from RTU.
- `rtu_prio_i`  in  g_prio_width  priority from RTU.
- `rsp_valid_o`  out  1  head entry available; drives core `rtu_rsp_valid_i` for this port.
- `rsp_ack_i`  in  1  core consumed the head entry; from core `rtu_rsp_ack_o`.
- `rsp_dst_port_mask_o`  out  g_num_ports  head mask.
- `rsp_drop_o`  out  1  head drop flag.
- `rsp_prio_o`  out  g_prio_width  head priority.
- `level_o`  out  log2(g_depth)+1  entries stored, including head.
- `overflow_o`  out  1  one-cycle pulse: response offered while not ready (lost).

## Operation
- Circular buffer of `g_depth` entries {mask, drop, prio}; write/read pointers one bit wider than the address, so full is address-equal with MSB different.
- Push: `rtu_valid_i & rtu_ready_o` at a rising edge stores the entry at the write pointer.
- Pop: `rsp_ack_i & rsp_valid_o` advances the read pointer. `rsp_ack_i` while `rsp_valid_o`=0 is ignored.
- `rtu_ready_o` is registered = not full after the current edge; no combinational path from `rsp_ack_i` or `rtu_valid_i`. When full, a same-cycle pop does not enable a push in that cycle; ready rises on the following cycle.
- Head output is registered, first-word-fall-through: on pop with more entries, the next entry appears the following cycle with `rsp_valid_o` held high (back-to-back acks drain one entry per cycle).
- When `rsp_valid_o`=0, data outputs hold the last presented entry.
- Simultaneous push and pop: `level_o` unchanged; order preserved (strict FIFO).
- Overflow: `rtu_valid_i`=1 while `rtu_ready_o`=0 drops the response; `overflow_o` pulses high the next cycle; queue contents unaffected.
- `level_o` counts 0..g_depth, never wraps.

## Timing
- Reset (asserted): all outputs 0, including `rtu_ready_o`; pointers cleared. `rtu_ready_o` rises on the first rising edge after release.
- Reset asserted mid-operation: all stored entries discarded immediately; outputs 0 asynchronously.
- Push into empty queue at edge N: `rsp_valid_o`=1 and data valid after edge N+1 (latency 1).
- Pop at edge N with level ≥2: next entry presented after edge N (no bubble). Pop of last entry: `rsp_valid_o`=0 after edge N.
- `level_o` updates on the same edge as the push/pop that changes it.

## Configuration
- `SWC_RTU_RSP_ZERO_MASK_DROP_EN` defined: an entry pushed with `rtu_dst_port_mask_i`=0 is stored with drop=1 regardless of `rtu_drop_i`; mask and prio stored unchanged.
- Undefined: drop stored exactly as received.

## Test plan
- Single entry: after reset, push {mask=0x005, drop=0, prio=5} -> `rsp_valid_o`=1 one cycle later with same fields; ack -> valid low next cycle, `level_o`=0.
- Fill g_depth=4: push 4 entries with prio 0..3, no ack -> `rtu_ready_o`=0 after 4th, `level_o`=4; 5th push -> `overflow_o` one-cycle pulse; drain with continuous ack -> prio 0,1,2,3 on consecutive cycles, entry 5 never appears.
- Concurrent push/pop at level 2 for 10 cycles -> `level_o` stays 2, output order equals input order.
- Ack while empty -> no state change, `level_o` stays 0, no spurious valid.
- Reset asserted with level 3 -> outputs 0 same cycle; after release `level_o`=0, `rtu_ready_o`=1 one edge later.
- Push mask=0, drop=0: with `SWC_RTU_RSP_ZERO_MASK_DROP_EN` -> `rsp_drop_o`=1; without -> `rsp_drop_o`=0.
